// File: rtl/display_compositor.sv
// Game-screen compositor: splash glyph, bird/pipe overlay, scoring and a blinking hit sequence.
// Define DISPLAY_HIT_BLINK_EN to build the HIT blink state; otherwise a collision goes straight to OVER.
module display_compositor #(
   parameter int ROWS      = 16,
   parameter int COLS      = 16,
   parameter int BIRD_COL  = 8,
   parameter int BIRD_W    = 2,
   parameter int BLINK_DIV = 4,
   parameter int BLINK_N   = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_tick,
   input  logic                       start,
   input  logic [ROWS-1:0]            bird,
   input  logic [ROWS-1:0][COLS-1:0]  pipe,
   output logic [ROWS-1:0][COLS-1:0]  RedPixels,
   output logic [ROWS-1:0][COLS-1:0]  GrnPixels,
   output logic                       gameover,
   output logic                       playing,
   output logic                       score
);

   localparam int ROFF = (ROWS - 16) / 2;
   localparam int COFF = (COLS - 16) / 2;

   generate
      if (ROWS < 16 || COLS < 16 || BIRD_W < 1 || BIRD_COL < 0 ||
          BIRD_COL + BIRD_W > COLS || BLINK_DIV < 1 || BLINK_N < 1) begin : g_bad_params
         $error("display_compositor: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {SPLASH = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;
   state_t state, state_next;

   logic start_q, start_rise, tick_play, collision, col_lit, col_q, score_next;
   logic [ROWS-1:0][COLS-1:0] glyph_img, bird_img, red_next, grn_next;

`ifdef DISPLAY_HIT_BLINK_EN
   localparam int FW = $clog2(BLINK_DIV) + 1;
   localparam int TW = $clog2(BLINK_N) + 1;
   logic [FW-1:0] frame_cnt, frame_cnt_next;
   logic [TW-1:0] tog_cnt, tog_cnt_next;
   logic          phase, phase_next;
`endif

   function automatic logic [15:0] glyph_row(input int r);
      case (r)
         5:       glyph_row = 16'h7400;
         6:       glyph_row = 16'h5400;
         7:       glyph_row = 16'h75CA;
         8:       glyph_row = 16'h454A;
         9:       glyph_row = 16'h45EE;
         10:      glyph_row = 16'h0002;
         11:      glyph_row = 16'h000E;
         default: glyph_row = 16'h0000;
      endcase
   endfunction

   assign start_rise = start & ~start_q;
   assign tick_play  = (state == PLAY) & frame_tick;

   always_comb begin
      logic [15:0] g;
      g         = '0;
      glyph_img = '0;
      for (int r = 0; r < 16; r++) begin
         g = glyph_row(r);
         for (int c = 0; c < 16; c++) glyph_img[r+ROFF][c+COFF] = g[c];
      end
   end

   always_comb begin
      collision = 1'b0;
      bird_img  = '0;
      for (int r = 0; r < ROWS; r++) begin
         collision = collision | (bird[r] & (|pipe[r][BIRD_COL +: BIRD_W]));
         for (int c = BIRD_COL; c < BIRD_COL + BIRD_W; c++) bird_img[r][c] = bird[r];
      end
   end

   // The scoring column sits just left of the bird; with the bird at column 0 there is none.
   generate
      if (BIRD_COL > 0) begin : g_score_col
         always_comb begin
            col_lit = 1'b0;
            for (int r = 0; r < ROWS; r++) col_lit = col_lit | pipe[r][BIRD_COL-1];
         end
      end else begin : g_no_score_col
         assign col_lit = 1'b0;
      end
   endgenerate

   // Collision wins over a simultaneous score edge.
   assign score_next = tick_play & col_lit & ~col_q & ~collision;

   always_comb begin
      state_next = state;
`ifdef DISPLAY_HIT_BLINK_EN
      frame_cnt_next = frame_cnt;
      tog_cnt_next   = tog_cnt;
      phase_next     = phase;
`endif
      case (state)
         SPLASH, OVER: if (start_rise) state_next = PLAY;
         PLAY: begin
            if (tick_play && collision) begin
`ifdef DISPLAY_HIT_BLINK_EN
               state_next = HIT;
`else
               state_next = OVER;
`endif
            end
         end
`ifdef DISPLAY_HIT_BLINK_EN
         HIT: begin
            if (frame_tick) begin
               if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                  frame_cnt_next = '0;
                  phase_next     = ~phase;
                  if (tog_cnt == TW'(BLINK_N - 1)) begin
                     state_next   = OVER;
                     tog_cnt_next = '0;
                     phase_next   = 1'b0;
                  end else begin
                     tog_cnt_next = tog_cnt + TW'(1);
                  end
               end else begin
                  frame_cnt_next = frame_cnt + FW'(1);
               end
            end
         end
`endif
         default: state_next = SPLASH;
      endcase
   end

   always_comb begin
      red_next = glyph_img;
      grn_next = '0;
      case (state)
         PLAY: begin
            red_next = bird_img;
            grn_next = pipe;
         end
         HIT: begin
`ifdef DISPLAY_HIT_BLINK_EN
            red_next = phase ? '0 : bird_img;
`endif
            grn_next = pipe;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= SPLASH;
         start_q   <= 1'b0;
         col_q     <= 1'b0;
         score     <= 1'b0;
         gameover  <= 1'b0;
         playing   <= 1'b0;
         RedPixels <= glyph_img;
         GrnPixels <= '0;
`ifdef DISPLAY_HIT_BLINK_EN
         frame_cnt <= '0;
         tog_cnt   <= '0;
         phase     <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         start_q   <= start;
         if (tick_play) col_q <= col_lit;
         score     <= score_next;
         gameover  <= (state == HIT) || (state == OVER);
         playing   <= (state == PLAY);
         RedPixels <= red_next;
         GrnPixels <= grn_next;
`ifdef DISPLAY_HIT_BLINK_EN
         frame_cnt <= frame_cnt_next;
         tog_cnt   <= tog_cnt_next;
         phase     <= phase_next;
`endif
      end
   end

endmodule

// File: tb/tb_display_compositor.sv
// Directed bench for display_compositor: default-size instance plus a 20x24 instance for glyph centring.
module tb_display_compositor;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic frame_tick = 1'b0;
   logic start = 1'b0;
   logic [15:0] bird = '0;
   logic [15:0][15:0] pipe = '0;
   logic [15:0][15:0] red, grn;
   logic gameover, playing, score;

   logic b_tick = 1'b0;
   logic b_start = 1'b0;
   logic [19:0] b_bird = '0;
   logic [19:0][23:0] b_pipe = '0;
   logic [19:0][23:0] b_red, b_grn;
   logic b_gameover, b_playing, b_score;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   display_compositor dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .bird(bird), .pipe(pipe), .RedPixels(red), .GrnPixels(grn),
      .gameover(gameover), .playing(playing), .score(score)
   );

   display_compositor #(.ROWS(20), .COLS(24)) dut_big (
      .clk(clk), .reset(reset), .frame_tick(b_tick), .start(b_start),
      .bird(b_bird), .pipe(b_pipe), .RedPixels(b_red), .GrnPixels(b_grn),
      .gameover(b_gameover), .playing(b_playing), .score(b_score)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      total++; if (red[7] !== 16'h75CA) begin bad++; $display("FAIL reset_row7: got %h want 75ca", red[7]); end
      total++; if (red[0] !== 16'h0000) begin bad++; $display("FAIL reset_row0: got %h want 0000", red[0]); end
      total++; if (grn !== '0) begin bad++; $display("FAIL reset_grn: got %h want 0", grn); end
      total++; if (gameover !== 1'b0 || playing !== 1'b0 || score !== 1'b0) begin
         bad++; $display("FAIL reset_flags: got go=%b pl=%b sc=%b want 000", gameover, playing, score);
      end
      tick();
      total++; if (red[5] !== 16'h7400 || red[11] !== 16'h000E) begin
         bad++; $display("FAIL splash_rows: got %h %h want 7400 000e", red[5], red[11]);
      end
   endtask

   task automatic test_start();
      int rises = 0;
      logic prev;
      prev = playing;
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (playing && !prev) rises++;
         prev = playing;
      end
      start = 1'b0;
      total++; if (rises != 1) begin bad++; $display("FAIL start_rises: got %0d want 1", rises); end
      total++; if (playing !== 1'b1) begin bad++; $display("FAIL start_playing: got %b want 1", playing); end
      tick();
      start = 1'b1;
      tick(); tick(); tick();
      start = 1'b0;
      tick();
      total++; if (playing !== 1'b1 || gameover !== 1'b0) begin
         bad++; $display("FAIL second_press: got pl=%b go=%b want 1 0", playing, gameover);
      end
   endtask

   task automatic test_play_image();
      bird = 16'h0040;
      pipe = '0;
      pipe[3][12] = 1'b1;
      pipe[10][2] = 1'b1;
      tick(); tick();
      total++; if (red[6] !== 16'h0300) begin bad++; $display("FAIL play_bird_row: got %h want 0300", red[6]); end
      total++; if (red[5] !== 16'h0000) begin bad++; $display("FAIL play_other_row: got %h want 0000", red[5]); end
      total++; if (grn[3] !== 16'h1000 || grn[10] !== 16'h0004) begin
         bad++; $display("FAIL play_grn: got %h %h want 1000 0004", grn[3], grn[10]);
      end
   endtask

   task automatic test_score();
      pipe = '0;
      frame();
      total++; if (score !== 1'b0) begin bad++; $display("FAIL score_empty: got %b want 0", score); end
      pipe[2][7] = 1'b1;
      tick();
      total++; if (score !== 1'b0) begin bad++; $display("FAIL score_no_tick: got %b want 0", score); end
      frame();
      total++; if (score !== 1'b1) begin bad++; $display("FAIL score_pulse: got %b want 1", score); end
      tick();
      total++; if (score !== 1'b0) begin bad++; $display("FAIL score_width: got %b want 0", score); end
      frame();
      total++; if (score !== 1'b0) begin bad++; $display("FAIL score_still_lit: got %b want 0", score); end
      total++; if (playing !== 1'b1) begin bad++; $display("FAIL score_playing: got %b want 1", playing); end
   endtask

   task automatic test_collision_score();
      pipe = '0;
      frame();
      pipe[2][7] = 1'b1;
      pipe[6][8] = 1'b1;
      frame();
      total++; if (score !== 1'b0) begin bad++; $display("FAIL coll_score: got %b want 0", score); end
      total++; if (gameover !== 1'b0 || playing !== 1'b1) begin
         bad++; $display("FAIL coll_latency: got go=%b pl=%b want 0 1", gameover, playing);
      end
      tick();
      total++; if (gameover !== 1'b1 || playing !== 1'b0 || score !== 1'b0) begin
         bad++; $display("FAIL coll_gameover: got go=%b pl=%b sc=%b want 1 0 0", gameover, playing, score);
      end
`ifdef DISPLAY_HIT_BLINK_EN
      total++; if (red[6][9:8] !== 2'b11 || grn[6] !== 16'h0100) begin
         bad++; $display("FAIL hit_first: got red=%b grn=%h want 11 0100", red[6][9:8], grn[6]);
      end
`else
      total++; if (red[7] !== 16'h75CA || grn !== '0) begin
         bad++; $display("FAIL over_glyph: got %h grn=%h want 75ca 0", red[7], grn);
      end
`endif
   endtask

`ifdef DISPLAY_HIT_BLINK_EN
   task automatic test_blink();
      logic [1:0] want;
      for (int k = 1; k <= 24; k++) begin
         frame();
         tick();
         if (k < 24) begin
            want = (((k / 4) % 2) == 1) ? 2'b00 : 2'b11;
            total++; if (red[6][9:8] !== want || gameover !== 1'b1) begin
               bad++; $display("FAIL blink_k%0d: got red=%b go=%b want %b 1", k, red[6][9:8], gameover, want);
            end
         end else begin
            total++; if (red[7] !== 16'h75CA || grn !== '0 || gameover !== 1'b1 || playing !== 1'b0) begin
               bad++; $display("FAIL blink_over: got row7=%h grn=%h go=%b pl=%b want 75ca 0 1 0",
                               red[7], grn, gameover, playing);
            end
         end
      end
   endtask
`endif

   task automatic test_reset_midgame();
      start = 1'b1; tick();
      start = 1'b0; tick();
      total++; if (playing !== 1'b1) begin bad++; $display("FAIL restart_play: got %b want 1", playing); end
      pipe = '0;
      pipe[2][7] = 1'b1;
      frame();
`ifdef DISPLAY_HIT_BLINK_EN
      pipe[6][8] = 1'b1;
      frame();
      for (int i = 0; i < 5; i++) frame();
`endif
      reset = 1'b0;
      tick();
      total++; if (dut.state !== 2'd0 || dut.col_q !== 1'b0 || dut.start_q !== 1'b0) begin
         bad++; $display("FAIL midreset_state: got st=%0d col=%b sq=%b want 0 0 0", dut.state, dut.col_q, dut.start_q);
      end
`ifdef DISPLAY_HIT_BLINK_EN
      total++; if (dut.frame_cnt !== '0 || dut.tog_cnt !== '0 || dut.phase !== 1'b0) begin
         bad++; $display("FAIL midreset_cnt: got f=%0d t=%0d p=%b want 0 0 0", dut.frame_cnt, dut.tog_cnt, dut.phase);
      end
`endif
      total++; if (red[7] !== 16'h75CA || grn !== '0 || gameover !== 1'b0 || playing !== 1'b0) begin
         bad++; $display("FAIL midreset_out: got row7=%h go=%b pl=%b want 75ca 0 0", red[7], gameover, playing);
      end
      reset = 1'b1;
      start = 1'b1; tick();
      start = 1'b0; tick();
      pipe = '0;
      pipe[2][7] = 1'b1;
      frame();
      total++; if (score !== 1'b1) begin bad++; $display("FAIL midreset_score: got %b want 1", score); end
   endtask

   task automatic test_big_glyph();
      total++; if (b_red[9][19:4] !== 16'h75CA) begin bad++; $display("FAIL big_row9: got %h want 75ca", b_red[9][19:4]); end
      total++; if (b_red[9][3:0] !== 4'h0 || b_red[9][23:20] !== 4'h0) begin
         bad++; $display("FAIL big_row9_edges: got %h %h want 0 0", b_red[9][3:0], b_red[9][23:20]);
      end
      total++; if (b_red[7][19:4] !== 16'h7400 || b_red[0] !== '0 || b_red[19] !== '0) begin
         bad++; $display("FAIL big_rows: got %h %h %h want 7400 0 0", b_red[7][19:4], b_red[0], b_red[19]);
      end
      total++; if (b_grn !== '0 || b_gameover !== 1'b0 || b_playing !== 1'b0 || b_score !== 1'b0) begin
         bad++; $display("FAIL big_flags: got go=%b pl=%b sc=%b", b_gameover, b_playing, b_score);
      end
   endtask

   initial begin
      test_reset();
      test_big_glyph();
      test_start();
      test_play_image();
      test_score();
      test_collision_score();
`ifdef DISPLAY_HIT_BLINK_EN
      test_blink();
`endif
      test_reset_midgame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_compositor.md
DISPLAY_COMPOSITOR -- requirements
Module: display_compositor

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: reset is synchronous and active-low, and the ports are named clk and reset.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- ROWS, 16, matrix rows; legal values are 16 or more.
- COLS, 16, matrix columns; legal values are 16 or more.
- BIRD_COL, 8, lowest column index of the bird.
- BIRD_W, 2, bird width in columns.
- BLINK_DIV, 4, frames per blink half-period.
- BLINK_N, 6, blink toggles before game over.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-low reset.
- frame_tick, in, 1, one-cycle pulse per frame.
- start, in, 1, level start button.
- bird, in, ROWS, bird occupancy; row 0 is the top.
- pipe, in, ROWS x COLS, pipe pixels, indexed [row][col].
- RedPixels, out, ROWS x COLS, red LEDs.
- GrnPixels, out, ROWS x COLS, green LEDs.
- gameover, out, 1, high in the HIT and OVER states.
- playing, out, 1, high in the PLAY state.
- score, out, 1, one-cycle score pulse.

Function
REQ-004 The state machine SHALL have four states: SPLASH, PLAY, HIT and OVER.
REQ-005 The start input SHALL be rising-edge detected using a registered copy of start; a start_rise is start high with the previous sample low.
REQ-006 SPLASH and OVER SHALL move to PLAY on start_rise; start_rise SHALL be ignored in PLAY and HIT.
REQ-007 A collision SHALL be an OR over all rows r of bird[r] AND (any of pipe[r][BIRD_COL .. BIRD_COL+BIRD_W-1]); it is evaluated only in cycles where PLAY and frame_tick are both high.
REQ-008 PLAY SHALL move to HIT on a collision, or to OVER when the block is built without DISPLAY_HIT_BLINK_EN.
REQ-009 Scoring SHALL track occupancy of column BIRD_COL-1 (any pixel lit), sampled into a register on every PLAY frame_tick:
- score pulses high for exactly one cycle, in the cycle after a frame_tick where that column is lit and the previous sample was unlit;
- when BIRD_COL is 0, score SHALL never assert.
REQ-010 A collision and a score event in the same frame SHALL resolve in favour of the collision; no score pulse is issued.
REQ-011 In HIT, a frame counter SHALL count frame_ticks:
- after every BLINK_DIV ticks, the blink phase toggles and a toggle counter increments;
- when the toggle counter reaches BLINK_N, the state moves to OVER and both counters clear.
REQ-012 Counter widths SHALL be clog2 of their terminal value plus 1; no counter wraps before its terminal value.
REQ-013 In SPLASH and OVER:
- GrnPixels SHALL be all 0.
- RedPixels SHALL show the 16x16 "Play" glyph placed with an offset of (ROWS-16)/2 rows and (COLS-16)/2 columns.
- Glyph rows 5 to 11 (bit 15 is the leftmost) are 0x7400, 0x5400, 0x75CA, 0x454A, 0x45EE, 0x0002, 0x000E; all other glyph rows are 0.
REQ-014 In PLAY, GrnPixels SHALL equal pipe, and RedPixels[r][c] SHALL equal bird[r] for c in BIRD_COL .. BIRD_COL+BIRD_W-1, and 0 elsewhere.
REQ-015 In HIT, GrnPixels SHALL equal pipe, and RedPixels SHALL be the PLAY bird image when the blink phase is 0 and all 0 when it is 1.
REQ-016 RedPixels, GrnPixels, gameover, playing and score SHALL all be registered, with a one-cycle latency from inputs and state to outputs.
REQ-017 Behaviour for illegal parameters, such as BIRD_COL+BIRD_W greater than COLS, SHALL be undefined; a synthesis-time assertion SHALL flag them.

Reset
REQ-018 While reset is low at a clock edge, the block SHALL load the following: state SPLASH, all counters 0, blink phase 0, start and column samples 0, score 0, gameover 0, playing 0.
REQ-019 The first output cycle after reset SHALL show the splash glyph with GrnPixels all 0.
REQ-020 Reset asserted in any state, including mid-blink, SHALL take effect at the next edge, with no partial score or blink carried over.

Configuration
REQ-021 The macro DISPLAY_HIT_BLINK_EN SHALL control the HIT state:
- Defined: the HIT state, its counters and the blink logic are present.
- Undefined: the HIT state and its counters are removed, a collision goes directly from PLAY to OVER, and gameover asserts in the cycle after the colliding frame_tick is registered.

Verification
REQ-022 A directed bench SHALL cover the following scenarios (stimulus -> required response), using default parameters unless stated:
- Reset low for 2 cycles then released -> RedPixels[7] = 0x75CA, RedPixels[0] = 0, GrnPixels = 0, gameover = 0.
- Start held high for 5 cycles -> exactly one SPLASH-to-PLAY transition; playing = 1; a second press during PLAY has no effect.
- PLAY with bird = 16'h0040 and pipe[6][8] = 1, then a frame_tick -> HIT. RedPixels[6][9:8] = 2'b11 for 4 frames, then 0 for 4 frames; after 24 frames gameover = 1 and the glyph is shown.
- PLAY with column 7 going empty, then lit on one frame_tick, with no collision -> score high for exactly 1 cycle; the next frame with column 7 still lit gives no pulse.
- A score edge and a collision on the same frame_tick -> no score pulse; state goes to HIT.
- Build without DISPLAY_HIT_BLINK_EN, then a collision -> OVER the cycle after the collision is registered; reset during HIT in a blink build -> SPLASH with all counters 0.
- Parameters ROWS = 20, COLS = 24 -> glyph row 0x75CA appears at row 9 starting at column 4.
